// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
package freq_meter_pkg;

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam int unsigned CLK_HZ_DEF = 50000000;
    localparam int unsigned CNT_W_DEF  = 32;

    function automatic int unsigned gate_cyc(input int unsigned clk_hz, input int unsigned gate_hz);
        return clk_hz / gate_hz;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble, one shift per cycle; present only with BCD_OUT_EN.
`ifdef BCD_OUT_EN
module bin2bcd_seq #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic [39:0]  bcd,
    output logic         done
);

    localparam int unsigned LW = $clog2(W + 1);

    logic [W-1:0]  sr;
    logic [39:0]   acc;
    logic [39:0]   adj;
    logic [LW-1:0] left;
    logic          active;

    always_comb begin
        adj = acc;
        for (int unsigned i = 0; i < 10; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // A start during a conversion simply reloads, restarting with the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr     <= '0;
            acc    <= '0;
            left   <= '0;
            active <= 1'b0;
            bcd    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr     <= bin;
                acc    <= '0;
                left   <= LW'(W);
                active <= 1'b1;
            end else if (active) begin
                acc  <= {adj[38:0], sr[W-1]};
                sr   <= sr << 1;
                left <= left - 1'b1;
                if (left == LW'(1)) begin
                    bcd    <= {adj[38:0], sr[W-1]};
                    done   <= 1'b1;
                    active <= 1'b0;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus a third flop; rise pulses for one cycle per rising edge.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Counts sig_in rising edges over a CLK_HZ/GATE_HZ-cycle gate window.
// Optional BCD_OUT_EN adds a BCD copy of the result (freq_bcd, bcd_valid).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
    parameter int unsigned GATE_HZ = 1,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             valid,
    output logic             busy,
    output logic             ovf
`ifdef BCD_OUT_EN
    ,
    output logic [39:0]      freq_bcd,
    output logic             bcd_valid
`endif
);

    localparam int unsigned GATE_CYC = gate_cyc(CLK_HZ, GATE_HZ);
    localparam int unsigned GATE_W   = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);

    state_t            state;
    logic [GATE_W-1:0] gate;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              sat;
    logic              sat_next;
    logic              rise;

    sync_edge u_sync (
        .clk  (clkin),
        .rst  (rst),
        .sig  (sig_in),
        .rise (rise)
    );

    always_comb begin
        cnt_next = cnt;
        if (rise && (cnt != '1))
            cnt_next = cnt + 1'b1;
        sat_next = sat | (cnt_next == '1);
    end

    // The terminal gate cycle wins over en=0 so a finished window is always published.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state <= IDLE;
            gate  <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            freq  <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate <= '0;
                    cnt  <= '0;
                    sat  <= 1'b0;
                    if (en) begin
                        state <= MEASURE;
                        busy  <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (gate == GATE_LAST) begin
                        freq  <= cnt_next;
                        ovf   <= sat_next;
                        valid <= 1'b1;
                        gate  <= '0;
                        cnt   <= '0;
                        sat   <= 1'b0;
                        if (!en) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        gate  <= '0;
                        cnt   <= '0;
                        sat   <= 1'b0;
                    end else begin
                        gate <= gate + 1'b1;
                        cnt  <= cnt_next;
                        sat  <= sat_next;
                    end
                end
            endcase
        end
    end

`ifdef BCD_OUT_EN
    bin2bcd_seq #(.W(CNT_W)) u_bcd (
        .clk   (clkin),
        .rst   (rst),
        .start (valid),
        .bin   (freq),
        .bcd   (freq_bcd),
        .done  (bcd_valid)
    );
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: CLK_HZ=1000, GATE_HZ=10 (100-cycle windows), CNT_W 32 and 4.
module tb_freq_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sig_in = 1'b0;
    int unsigned per = 0;
    logic        hold = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] freq_a;
    logic        valid_a, busy_a, ovf_a;
    logic [3:0]  freq_s;
    logic        valid_s, busy_s, ovf_s;
`ifdef BCD_OUT_EN
    logic [39:0] bcd_a, bcd_s;
    logic        bcd_valid_a, bcd_valid_s;
`endif

    always #5 clk = ~clk;

    freq_meter #(.CLK_HZ(1000), .GATE_HZ(10), .CNT_W(32)) u_dut (
        .clkin  (clk),
        .rst    (rst),
        .en     (en),
        .sig_in (sig_in),
        .freq   (freq_a),
        .valid  (valid_a),
        .busy   (busy_a),
        .ovf    (ovf_a)
`ifdef BCD_OUT_EN
        ,
        .freq_bcd  (bcd_a),
        .bcd_valid (bcd_valid_a)
`endif
    );

    freq_meter #(.CLK_HZ(1000), .GATE_HZ(10), .CNT_W(4)) u_sat (
        .clkin  (clk),
        .rst    (rst),
        .en     (en),
        .sig_in (sig_in),
        .freq   (freq_s),
        .valid  (valid_s),
        .busy   (busy_s),
        .ovf    (ovf_s)
`ifdef BCD_OUT_EN
        ,
        .freq_bcd  (bcd_s),
        .bcd_valid (bcd_valid_s)
`endif
    );

    // Square wave of 'per' clocks (half high, half low), or a constant level when per==0.
    initial begin
        int unsigned ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (per == 0) begin
                sig_in = hold;
            end else begin
                ph = (ph + 1) % per;
                sig_in = (ph < per / 2);
            end
        end
    end

    task automatic wait_valid(input int unsigned limit, output int unsigned n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_a && n < limit);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (freq_a !== 32'd0) begin errors++; $display("FAIL reset_freq: got %0d expected 0", freq_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_a); end
        checks++; if (freq_s !== 4'd0) begin errors++; $display("FAIL reset_freq_sat: got %0d expected 0", freq_s); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy_a); end
    endtask

    task automatic test_count();
        int unsigned n;
        int unsigned first_a, first_s;
        logic [39:0] got_a, got_s;
        first_a = 0; first_s = 0; got_a = '0; got_s = '0;
        per = 4;
        repeat (20) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL entry_busy: got %b expected 1", busy_a); end
        wait_valid(200, n);
        checks++; if (n !== 100) begin errors++; $display("FAIL first_latency: got %0d expected 100", n); end
        checks++; if (freq_a !== 32'd25) begin errors++; $display("FAIL count_freq: got %0d expected 25", freq_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL count_ovf: got %b expected 0", ovf_a); end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: got %b expected 0", valid_a); end
            end
`ifdef BCD_OUT_EN
            if (bcd_valid_a === 1'b1 && first_a == 0) begin first_a = k; got_a = bcd_a; end
            if (bcd_valid_s === 1'b1 && first_s == 0) begin first_s = k; got_s = bcd_s; end
`endif
        end
`ifdef BCD_OUT_EN
        checks++; if (first_a !== 33) begin errors++; $display("FAIL bcd_latency: got %0d expected 33", first_a); end
        checks++; if (got_a !== 40'h0000000025) begin errors++; $display("FAIL bcd_value: got %h expected 0000000025", got_a); end
        checks++; if (first_s !== 5) begin errors++; $display("FAIL bcd_latency_sat: got %0d expected 5", first_s); end
        checks++; if (got_s !== 40'h0000000015) begin errors++; $display("FAIL bcd_value_sat: got %h expected 0000000015", got_s); end
`endif
        wait_valid(100, n);
        checks++; if (n !== 60) begin errors++; $display("FAIL back_to_back_period: got %0d expected 60", n); end
        checks++; if (freq_a !== 32'd25) begin errors++; $display("FAIL back_to_back_freq: got %0d expected 25", freq_a); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL back_to_back_busy: got %b expected 1", busy_a); end
    endtask

    task automatic test_constant();
        int unsigned n;
        per = 0;
        hold = 1'b1;
        wait_valid(120, n);
        wait_valid(120, n);
        checks++; if (n !== 100) begin errors++; $display("FAIL const_period: got %0d expected 100", n); end
        checks++; if (freq_a !== 32'd0) begin errors++; $display("FAIL const_freq: got %0d expected 0", freq_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL const_ovf: got %b expected 0", ovf_a); end
    endtask

    task automatic test_saturation();
        int unsigned n;
        per = 2;
        wait_valid(120, n);
        wait_valid(120, n);
        checks++; if (valid_s !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b expected 1", valid_s); end
        checks++; if (freq_s !== 4'd15) begin errors++; $display("FAIL sat_freq: got %0d expected 15", freq_s); end
        checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", ovf_s); end
        checks++; if (freq_a !== 32'd50) begin errors++; $display("FAIL wide_freq: got %0d expected 50", freq_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL wide_ovf: got %b expected 0", ovf_a); end
    endtask

    task automatic test_abort();
        int unsigned n;
        int unsigned pulses;
        per = 4;
        wait_valid(120, n);
        wait_valid(120, n);
        checks++; if (freq_a !== 32'd25) begin errors++; $display("FAIL abort_window1: got %0d expected 25", freq_a); end
        repeat (50) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy_a); end
        pulses = 0;
        repeat (150) begin
            @(negedge clk);
            if (valid_a === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", pulses); end
        checks++; if (freq_a !== 32'd25) begin errors++; $display("FAIL abort_hold_freq: got %0d expected 25", freq_a); end
    endtask

    task automatic test_reset_mid();
        int unsigned n;
        en = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_busy: got %b expected 1", busy_a); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (freq_a !== 32'd0) begin errors++; $display("FAIL rst_mid_freq: got %0d expected 0", freq_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", valid_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy_a); end
        checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf_sat: got %b expected 0", ovf_s); end
        rst = 1'b0;
        wait_valid(200, n);
        checks++; if (n !== 101) begin errors++; $display("FAIL rst_mid_relatency: got %0d expected 101", n); end
        wait_valid(120, n);
        checks++; if (freq_a !== 32'd25) begin errors++; $display("FAIL rst_mid_recount: got %0d expected 25", freq_a); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_constant();
        test_saturation();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
